// File: rtl/vectrex_cart_loader.sv
// Cartridge download front end: filters the ioctl byte stream into cart RAM writes,
// tracks the cart address mask and image size, and generates the core reset.
module vectrex_cart_loader #(
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 5000000,
  parameter int RST_LEN = 1000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              skip_logo,
  output logic              cart_wr,
  output logic [ADDR_W-1:0] cart_addr,
  output logic [7:0]        cart_data,
  output logic [ADDR_W-1:0] cart_mask,
  output logic [ADDR_W:0]   cart_size,
  output logic              overflow,
  output logic              core_reset
);

  // state | meaning
  // IDLE  | no download, no pending reset pulse
  // LOAD  | download in progress, bytes forwarded to cart RAM
  // WAIT  | download ended with skip_logo, counting towards the second reset
  // PULSE | second reset pulse asserted for RST_LEN cycles

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - RST_LEN - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_LEN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, PULSE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              dl_q;
  logic              dl_rise, dl_fall;
  logic              in_window, load_wr, wr_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   wr_end;

  assign dl_rise   = ioctl_download & ~dl_q;
  assign dl_fall   = ~ioctl_download & dl_q;
  assign in_window = (ioctl_addr[24:ADDR_W] == '0);
  assign load_wr   = (state == LOAD) && ioctl_wr;
  assign wr_ok     = load_wr && in_window;
  assign wr_addr   = ioctl_addr[ADDR_W-1:0];
  assign wr_end    = {1'b0, wr_addr} + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (dl_rise) begin
      // a new download always wins, aborting any pending second reset
      state_nxt = LOAD;
      cnt_nxt   = '0;
    end else begin
      case (state)
        LOAD: begin
          if (dl_fall) begin
            state_nxt = skip_logo ? WAIT : IDLE;
            cnt_nxt   = '0;
          end
        end
        WAIT: begin
          if (cnt == WAIT_LAST) begin
            state_nxt = PULSE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt == PULSE_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dl_q       <= 1'b0;
      core_reset <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dl_q       <= ioctl_download;
      core_reset <= dl_q | (state == PULSE);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cart_wr   <= 1'b0;
      cart_addr <= '0;
      cart_data <= '0;
    end else begin
      cart_wr <= wr_ok;
      if (wr_ok) begin
        cart_addr <= wr_addr;
        cart_data <= ioctl_dout;
      end
    end
  end

  // mask grows by at most one bit per write, so it tracks a power-of-two window
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cart_mask <= '0;
      cart_size <= '0;
      overflow  <= 1'b0;
    end else if (dl_rise) begin
      cart_mask <= '0;
      cart_size <= '0;
      overflow  <= 1'b0;
    end else if (load_wr) begin
      if (in_window) begin
        if ((wr_addr & ~cart_mask) != '0)
          cart_mask <= {cart_mask[ADDR_W-2:0], 1'b1};
        if (wr_end > cart_size)
          cart_size <= wr_end;
      end else begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vectrex_cart_loader.sv
// Bench for vectrex_cart_loader: cart writes checked by a scoreboard monitor,
// mask/size/overflow/core_reset checked against hand-computed values.
module tb_vectrex_cart_loader;
  localparam int ADDR_W = 15;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              skip_logo;
  logic              cart_wr;
  logic [ADDR_W-1:0] cart_addr;
  logic [7:0]        cart_data;
  logic [ADDR_W-1:0] cart_mask;
  logic [ADDR_W:0]   cart_size;
  logic              overflow;
  logic              core_reset;

  vectrex_cart_loader #(.ADDR_W(ADDR_W), .TIMEOUT(20), .RST_LEN(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .skip_logo(skip_logo), .cart_wr(cart_wr), .cart_addr(cart_addr),
    .cart_data(cart_data), .cart_mask(cart_mask), .cart_size(cart_size),
    .overflow(overflow), .core_reset(core_reset)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+7:0] exp_q[$];
  logic [ADDR_W+7:0] exp_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit acc);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (acc) exp_q.push_back({a[ADDR_W-1:0], d});
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic load_range(input int n);
    for (int i = 0; i < n; i++) wr_byte(25'(i), 8'(i) ^ 8'h5A, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cart_wr"},    32'(cart_wr),    32'h0);
    chk({tag, "_cart_addr"},  32'(cart_addr),  32'h0);
    chk({tag, "_cart_data"},  32'(cart_data),  32'h0);
    chk({tag, "_cart_mask"},  32'(cart_mask),  32'h0);
    chk({tag, "_cart_size"},  32'(cart_size),  32'h0);
    chk({tag, "_overflow"},   32'(overflow),   32'h0);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'h0);
  endtask

  always @(negedge clk_sys) begin
    if (cart_wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cart_wr_unexpected addr=%0h data=%0h expected=no write", cart_addr, cart_data);
      end else begin
        exp_wr = exp_q.pop_front();
        if ({cart_addr, cart_data} !== exp_wr) begin
          errors++;
          $display("FAIL cart_wr_data actual=%0h/%0h expected=%0h/%0h",
                   cart_addr, cart_data, exp_wr[ADDR_W+7:8], exp_wr[7:0]);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; skip_logo = 1'b0;
    #12;
    chk_all_zero("reset");
    step();
    reset_n = 1'b1;
    step();

    // 4 KiB image, last byte on the download-fall cycle
    ioctl_download = 1'b1;
    step();
    chk("t1_core_reset_lag", 32'(core_reset), 32'h0);
    load_range(4095);
    chk("t1_core_reset_load", 32'(core_reset), 32'h1);
    ioctl_download = 1'b0;
    wr_byte(25'h0FFF, 8'hA5, 1'b1);
    chk("t1_core_reset_c0", 32'(core_reset), 32'h1);
    step();
    chk("t1_core_reset_c1", 32'(core_reset), 32'h0);
    chk("t1_mask", 32'(cart_mask), 32'h0FFF);
    chk("t1_size", 32'(cart_size), 32'h1000);
    chk("t1_overflow", 32'(overflow), 32'h0);

    // full 32 KiB window, then a short reload
    ioctl_download = 1'b1;
    step();
    chk("t2_mask_clr", 32'(cart_mask), 32'h0);
    chk("t2_size_clr", 32'(cart_size), 32'h0);
    load_range(32768);
    ioctl_download = 1'b0;
    step(); step();
    chk("t2_mask_full", 32'(cart_mask), 32'h7FFF);
    chk("t2_size_full", 32'(cart_size), 32'h8000);
    chk("t2_overflow", 32'(overflow), 32'h0);
    ioctl_download = 1'b1;
    step();
    chk("t2_mask_reclr", 32'(cart_mask), 32'h0);
    chk("t2_size_reclr", 32'(cart_size), 32'h0);
    load_range(16);
    ioctl_download = 1'b0;
    step();
    chk("t2_mask_16", 32'(cart_mask), 32'h000F);
    chk("t2_size_16", 32'(cart_size), 32'h0010);

    // out-of-window bytes, top-of-window byte, write outside LOAD
    ioctl_download = 1'b1;
    step();
    load_range(4);
    wr_byte(25'h0008000, 8'h11, 1'b0);
    wr_byte(25'h0010000, 8'h22, 1'b0);
    chk("t3_overflow", 32'(overflow), 32'h1);
    chk("t3_mask_keep", 32'(cart_mask), 32'h3);
    chk("t3_size_keep", 32'(cart_size), 32'h4);
    wr_byte(25'h0007FFF, 8'h33, 1'b1);
    chk("t3_mask_onebit", 32'(cart_mask), 32'h7);
    chk("t3_size_top", 32'(cart_size), 32'h8000);
    ioctl_download = 1'b0;
    step(); step();
    wr_byte(25'h0000005, 8'h44, 1'b0);
    step();
    chk("t3_overflow_hold", 32'(overflow), 32'h1);
    chk("t3_mask_hold", 32'(cart_mask), 32'h7);
    chk("t3_size_hold", 32'(cart_size), 32'h8000);

    // skip_logo second reset pulse
    ioctl_download = 1'b1;
    step();
    chk("t4_overflow_clr", 32'(overflow), 32'h0);
    load_range(2);
    skip_logo = 1'b1;
    ioctl_download = 1'b0;
    step();
    skip_logo = 1'b0;
    chk("t4_core_reset_c0", 32'(core_reset), 32'h1);
    for (int k = 1; k <= 30; k++) begin
      step();
      chk($sformatf("t4_pulse_c%0d", k), 32'(core_reset), (k >= 17 && k <= 20) ? 32'h1 : 32'h0);
    end

    // new download during WAIT aborts the pulse
    ioctl_download = 1'b1;
    step();
    load_range(2);
    skip_logo = 1'b1;
    ioctl_download = 1'b0;
    step();
    skip_logo = 1'b0;
    repeat (4) step();
    ioctl_download = 1'b1;
    step();
    chk("t5_core_reset_rise", 32'(core_reset), 32'h0);
    chk("t5_mask_clr", 32'(cart_mask), 32'h0);
    step();
    chk("t5_core_reset_follow", 32'(core_reset), 32'h1);
    step();
    ioctl_download = 1'b0;
    step();
    chk("t5_core_reset_c0", 32'(core_reset), 32'h1);
    for (int k = 1; k <= 25; k++) begin
      step();
      chk($sformatf("t5_nopulse_c%0d", k), 32'(core_reset), 32'h0);
    end

    // reset pulse mid-LOAD with download held high
    ioctl_download = 1'b1;
    step();
    load_range(8);
    step();
    chk("t6_mask_pre", 32'(cart_mask), 32'h7);
    reset_n = 1'b0;
    ioctl_wr = 1'b1;
    ioctl_addr = 25'h20;
    ioctl_dout = 8'h66;
    #1;
    chk_all_zero("t6_async");
    step();
    chk("t6_cart_wr_rst", 32'(cart_wr), 32'h0);
    chk("t6_core_reset_rst", 32'(core_reset), 32'h0);
    reset_n = 1'b1;
    ioctl_wr = 1'b0;
    step();
    chk("t6_core_reset_rise", 32'(core_reset), 32'h0);
    chk("t6_mask_restart", 32'(cart_mask), 32'h0);
    step();
    chk("t6_core_reset_load", 32'(core_reset), 32'h1);
    wr_byte(25'h10, 8'h77, 1'b1);
    chk("t6_mask_after", 32'(cart_mask), 32'h1);
    chk("t6_size_after", 32'(cart_size), 32'h11);
    ioctl_download = 1'b0;
    step(); step();
    chk("t6_core_reset_end", 32'(core_reset), 32'h0);

    repeat (3) step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
